// File: rtl/mem_interface_pkg.sv
// Shared types and helpers for the EX -> LSU -> MEM_Stage data path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a; the handshake fields live in mem_req_t / mem_resp_t.
package mem_interface_pkg;

    // Request towards MEM_Stage; valid is held with all fields until ready.
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // Response from MEM_Stage: ready accepts a request, rvalid returns load data.
    typedef struct packed {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
    } mem_resp_t;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_REQ   = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_DRAIN = 2'd3
    } lsu_state_e;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Exception cause codes
    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

    // Byte lanes touched by an access of the given width at the given offset.
    function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] funct3);
        return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] funct3);
        return funct3 inside {F3_SB, F3_SH, F3_SW};
    endfunction

    // Halves need bit 0 clear, words need both low bits clear.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3[1:0] == 2'b01) && off[0]) ||
               ((funct3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    // Narrow stores are replicated across the word so any lane selected by be is correct.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            F3_SB:   d = {4{wdata[7:0]}};
            F3_SH:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of rdata and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module lsu_load_align
    import mem_interface_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by address offset, then sign- or zero-extend per funct3.
    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: captures one EX op, issues a mem_req_t, returns aligned load data or an exception.
// Latency: load with immediate ready and rvalid one cycle later gives wb_valid_o 3 cycles after capture.
// Backpressure: request held until d_resp_i.ready; lsu_stall_o freezes upstream while an access is in flight.
module lsu_ctrl
    import mem_interface_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    input  logic            ex_is_load_i,
    input  logic            ex_is_store_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            flush_i,
    output logic            lsu_stall_o,
    output mem_req_t        d_req_o,
    input  mem_resp_t       d_resp_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            exc_valid_o,
    output logic [3:0]      exc_cause_o,
    output logic [XLEN-1:0] exc_tval_o
);

    // Counter counts WAIT cycles 0..RESP_TIMEOUT-1; one bit is enough when the timeout is off.
    localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

    lsu_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [4:0]        rd_q, rd_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              exc_valid_q, exc_valid_d;
    logic [3:0]        exc_cause_q, exc_cause_d;
    logic [31:0]       exc_tval_q, exc_tval_d;

    logic              ex_take;
    logic              ex_f3_ok;
    logic              ex_misal;
    logic [31:0]       align_data;

    assign ex_take  = ex_valid_i && (ex_is_load_i || ex_is_store_i) && !flush_i;
    assign ex_f3_ok = ex_is_load_i ? load_f3_ok(ex_funct3_i) : store_f3_ok(ex_funct3_i);
    assign ex_misal = misaligned(ex_funct3_i, ex_addr_i[1:0]);

    lsu_load_align u_align (
        .rdata_i  (d_resp_i.rdata),
        .funct3_i (funct3_q),
        .off_i    (addr_q[1:0]),
        .data_o   (align_data)
    );

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        tmo_d       = tmo_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_tval_d  = exc_tval_q;

        case (state_q)
            LSU_IDLE: begin
                if (ex_take) begin
                    if (!ex_f3_ok) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = EXC_ILLEGAL;
                        exc_tval_d  = ex_addr_i;
                    end else if (ex_misal) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = ex_is_load_i ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
                        exc_tval_d  = ex_addr_i;
                    end else begin
                        state_d     = LSU_REQ;
                        req_d.valid = 1'b1;
                        req_d.we    = !ex_is_load_i;
                        req_d.addr  = ex_addr_i;
                        req_d.wdata = ex_is_load_i ? 32'd0 : store_data(ex_funct3_i, ex_wdata_i);
                        req_d.be    = be_for(ex_funct3_i, ex_addr_i[1:0]);
                        funct3_d    = ex_funct3_i;
                        addr_d      = ex_addr_i;
                        rd_d        = ex_rd_i;
                    end
                end
            end

            LSU_REQ: begin
                // An accepted transfer is committed even if flushed in the same cycle.
                if (d_resp_i.ready) begin
                    req_d = '0;
                    tmo_d = '0;
                    if (req_q.we) begin
                        state_d = LSU_IDLE;
                    end else if (flush_i) begin
                        state_d = LSU_DRAIN;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else if (flush_i) begin
                    req_d   = '0;
                    state_d = LSU_IDLE;
                end
            end

            LSU_WAIT: begin
                // A response arriving with a flush is consumed silently; nothing left to drain.
                if (d_resp_i.rvalid) begin
                    state_d = LSU_IDLE;
                    if (!flush_i) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = align_data;
                    end
                end else if (flush_i) begin
                    state_d = LSU_DRAIN;
                end else if (RESP_TIMEOUT > 0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d     = LSU_IDLE;
                        exc_valid_d = 1'b1;
                        exc_cause_d = EXC_LD_FAULT;
                        exc_tval_d  = addr_q;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            LSU_DRAIN: begin
                if (d_resp_i.rvalid) begin
                    state_d = LSU_IDLE;
                end
            end

            default: state_d = LSU_IDLE;
        endcase
    end

    // State and output registers; reset abandons any access without a wb or exc.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LSU_IDLE;
            req_q       <= '0;
            funct3_q    <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            tmo_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_tval_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            tmo_q       <= tmo_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    assign lsu_stall_o = (state_q != LSU_IDLE);
    assign d_req_o     = req_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_tval_o  = exc_tval_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed scenarios followed by randomized ops.
// Expected requests, writebacks and exceptions are queued by the driver and popped by a monitor.
// Timing-critical properties (stall length, wb latency, reset) are checked inline by the driver.
module tb_lsu_ctrl;
    import mem_interface_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_is_load_i = 1'b0;
    logic        ex_is_store_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [31:0] ex_addr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic [4:0]  ex_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        lsu_stall_o;
    mem_req_t    d_req_o;
    mem_resp_t   d_resp_i = '0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_valid_o;
    logic [3:0]  exc_cause_o;
    logic [31:0] exc_tval_o;

    lsu_ctrl #(.XLEN(32), .RESP_TIMEOUT(0)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .ex_is_load_i (ex_is_load_i),
        .ex_is_store_i(ex_is_store_i),
        .ex_funct3_i  (ex_funct3_i),
        .ex_addr_i    (ex_addr_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_rd_i      (ex_rd_i),
        .flush_i      (flush_i),
        .lsu_stall_o  (lsu_stall_o),
        .d_req_o      (d_req_o),
        .d_resp_i     (d_resp_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .exc_valid_o  (exc_valid_o),
        .exc_cause_o  (exc_cause_o),
        .exc_tval_o   (exc_tval_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [69:0] exp_req_q[$];
    logic [36:0] exp_wb_q[$];
    logic [35:0] exp_exc_q[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference load extraction from plain shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rdata >> (8 * int'(off));
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v[7])  v = v | 32'hFFFFFF00; end
            3'd1: begin v = sh & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
            3'd4: v = sh & 32'hFF;
            3'd5: v = sh & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (d_req_o.valid) begin
                if (exp_req_q.size() == 0) chk("req_unexpected", 128'(d_req_o), 128'(0));
                else begin
                    chk("req", 128'(d_req_o), 128'(exp_req_q[0]));
                    if (d_resp_i.ready || flush_i) void'(exp_req_q.pop_front());
                end
            end
            if (wb_valid_o) begin
                if (exp_wb_q.size() == 0) chk("wb_unexpected", 128'({wb_rd_o, wb_data_o}), 128'(0));
                else chk("wb", 128'({wb_rd_o, wb_data_o}), 128'(exp_wb_q.pop_front()));
            end
            if (exc_valid_o) begin
                if (exp_exc_q.size() == 0) chk("exc_unexpected", 128'({exc_cause_o, exc_tval_o}), 128'(0));
                else chk("exc", 128'({exc_cause_o, exc_tval_o}), 128'(exp_exc_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // op: 0 none, 1 load, 2 store. fmode: 0 none, 1 flush in WAIT, 2 flush in REQ, 3 flush at capture.
    task automatic do_op(input int op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int rdy_dly, input int rv_dly, input int fmode, input bit lat);
        bit ld;
        bit accepted;
        bit legal;
        int size;
        mem_req_t e;
        int w;
        ld = (op == 1);
        accepted = 1'b0;
        w = 0;
        while (lsu_stall_o && w < 20) begin tick(); w++; end
        if (lsu_stall_o) chk("idle_timeout", 128'(lsu_stall_o), 128'(0));
        ex_valid_i = 1'b1; ex_is_load_i = ld; ex_is_store_i = (op == 2);
        ex_funct3_i = f3; ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
        flush_i = (fmode == 3);
        if (op != 0 && fmode != 3) begin
            legal = ld ? (int'(f3) inside {0, 1, 2, 4, 5}) : (f3 <= 3'd2);
            size = 1 << (int'(f3) % 4);
            if (!legal) exp_exc_q.push_back({EXC_ILLEGAL, addr});
            else if ((addr % size) != 0) exp_exc_q.push_back({ld ? 4'd4 : 4'd6, addr});
            else begin
                accepted = 1'b1;
                e.valid = 1'b1; e.we = !ld; e.addr = addr;
                e.wdata = ld ? 32'd0 : (size == 1 ? (wdata & 32'hFF) * 32'h01010101 :
                                        size == 2 ? (wdata & 32'hFFFF) * 32'h00010001 : wdata);
                e.be = (size == 4) ? 4'hF : 4'((size == 1 ? 1 : 3) << (addr % 4));
                exp_req_q.push_back(e);
            end
        end
        tick();
        ex_valid_i = 1'b0; flush_i = 1'b0;
        if (!accepted) return;
        chk("stall_req", 128'(lsu_stall_o), 128'(1));
        if (fmode == 2) begin
            flush_i = 1'b1; tick(); flush_i = 1'b0;
            chk("stall_after_req_flush", 128'(lsu_stall_o), 128'(0));
            return;
        end
        repeat (rdy_dly) begin tick(); chk("stall_req_hold", 128'(lsu_stall_o), 128'(1)); end
        d_resp_i.ready = 1'b1;
        d_resp_i.rvalid = 1'($urandom_range(0, 1));
        d_resp_i.rdata = $urandom;
        tick();
        d_resp_i.ready = 1'b0; d_resp_i.rvalid = 1'b0;
        if (!ld) begin chk("stall_store_done", 128'(lsu_stall_o), 128'(0)); return; end
        chk("stall_wait", 128'(lsu_stall_o), 128'(1));
        if (lat) chk("lat_wb_early", 128'(wb_valid_o), 128'(0));
        if (fmode == 1) begin
            flush_i = 1'b1; tick(); flush_i = 1'b0;
            repeat (rv_dly - 1) begin tick(); chk("stall_drain", 128'(lsu_stall_o), 128'(1)); end
            d_resp_i.rvalid = 1'b1; d_resp_i.rdata = rdata;
            tick();
            d_resp_i.rvalid = 1'b0;
            chk("stall_after_drain", 128'(lsu_stall_o), 128'(0));
            return;
        end
        exp_wb_q.push_back({rd, ref_load(f3, addr[1:0], rdata)});
        repeat (rv_dly - 1) tick();
        d_resp_i.rvalid = 1'b1; d_resp_i.rdata = rdata;
        tick();
        d_resp_i.rvalid = 1'b0; d_resp_i.rdata = $urandom;
        chk("stall_wb", 128'(lsu_stall_o), 128'(0));
        if (lat) chk("lat_wb", 128'(wb_valid_o), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int r;
        int fm;
        logic [2:0] f3;
        logic [2:0] f3_ld[5];
        logic [31:0] a;
        f3_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        #1 rst_ni = 1'b0;
        #1;
        chk("rst_stall", 128'(lsu_stall_o), 128'(0));
        chk("rst_req", 128'(d_req_o), 128'(0));
        chk("rst_outs", 128'({wb_valid_o, wb_rd_o, wb_data_o, exc_valid_o, exc_cause_o, exc_tval_o}), 128'(0));
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // LW with immediate ready and rvalid: latency and stall length
        do_op(1, 3'd2, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, 1, 0, 1'b1);
        // Byte/half extraction and extension
        do_op(1, 3'd0, 32'h103, 32'h0, 5'd3, 32'h80FFFFFF, 0, 1, 0, 1'b0);
        do_op(1, 3'd4, 32'h103, 32'h0, 5'd4, 32'h80FFFFFF, 1, 2, 0, 1'b0);
        do_op(1, 3'd5, 32'h102, 32'h0, 5'd5, 32'h80FFFFFF, 0, 1, 0, 1'b0);
        // SH held through three not-ready cycles
        do_op(2, 3'd1, 32'h102, 32'h1234ABCD, 5'd0, 32'h0, 3, 1, 0, 1'b0);
        // Misaligned load and illegal store funct3
        do_op(1, 3'd2, 32'h101, 32'h0, 5'd1, 32'h0, 0, 1, 0, 1'b0);
        do_op(2, 3'd3, 32'h200, 32'h55, 5'd0, 32'h0, 0, 1, 0, 1'b0);
        // Flush in WAIT, then a normal load
        do_op(1, 3'd2, 32'h300, 32'h0, 5'd9, 32'h11112222, 0, 2, 1, 1'b0);
        do_op(1, 3'd2, 32'h304, 32'h0, 5'd10, 32'hCAFEF00D, 0, 1, 0, 1'b0);

        // Reset in the middle of WAIT
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_is_store_i = 1'b0;
        ex_funct3_i = 3'd2; ex_addr_i = 32'h400; ex_rd_i = 5'd12;
        exp_req_q.push_back({1'b1, 1'b0, 32'h400, 32'h0, 4'hF});
        tick();
        ex_valid_i = 1'b0; d_resp_i.ready = 1'b1;
        tick();
        d_resp_i.ready = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_stall", 128'(lsu_stall_o), 128'(0));
        chk("midrst_req", 128'(d_req_o), 128'(0));
        chk("midrst_outs", 128'({wb_valid_o, wb_rd_o, wb_data_o, exc_valid_o, exc_cause_o, exc_tval_o}), 128'(0));
        d_resp_i.rvalid = 1'b1; d_resp_i.rdata = 32'h12345678;
        tick();
        d_resp_i.rvalid = 1'b0;
        rst_ni = 1'b1;
        tick();
        do_op(1, 3'd2, 32'h408, 32'h0, 5'd13, 32'h87654321, 0, 1, 0, 1'b0);

        // Randomized ops
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            op = (r == 0) ? 0 : (r <= 5) ? 1 : 2;
            if ($urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 7));
            else if (op == 1) f3 = f3_ld[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            fm = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
            do_op(op, f3, a, $urandom, 5'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 3), fm, 1'b0);
        end

        repeat (5) tick();
        chk("sb_req_empty", 128'(exp_req_q.size()), 128'(0));
        chk("sb_wb_empty", 128'(exp_wb_q.size()), 128'(0));
        chk("sb_exc_empty", 128'(exp_exc_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control unit between the EX stage and MEM_Stage.
- Captures one memory op from EX, builds a `mem_req_t` (byte enables, replicated store data) and drives it to MEM_Stage under a valid/ready handshake.
- Waits for the `mem_resp_t` read data, then aligns and sign/zero-extends load data and presents it to writeback.
- Detects misaligned and illegal accesses, raises exceptions, and stalls the pipeline while an access is in flight.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- RESP_TIMEOUT, 0, cycles to wait for rvalid before a load access fault; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX presents an op this cycle
- ex_is_load_i  in  1  op is a load
- ex_is_store_i  in  1  op is a store
- ex_funct3_i  in  3  RISC-V width/sign funct3
- ex_addr_i  in  32  effective address
- ex_wdata_i  in  32  store data (rs2)
- ex_rd_i  in  5  load destination register
- flush_i  in  1  kill the in-flight or presented op
- lsu_stall_o  out  1  freeze upstream pipeline
- d_req_o  out  mem_req_t  {valid, we, addr[31:0], wdata[31:0], be[3:0]} to MEM_Stage
- d_resp_i  in  mem_resp_t  {ready, rvalid, rdata[31:0]} from MEM_Stage
- wb_valid_o  out  1  load result valid (one-cycle pulse)
- wb_rd_o  out  5  load destination
- wb_data_o  out  32  extended load data
- exc_valid_o  out  1  exception pulse
- exc_cause_o  out  4  2 illegal, 4 load misaligned, 5 load access fault, 6 store misaligned
- exc_tval_o  out  32  faulting address

Behaviour:
- Reset: the asynchronous active-low reset (`rst_ni`) clears everything.
  - FSM goes to IDLE; all outputs 0, including `d_req_o` all-zero.
  - Asserting reset mid-operation abandons the access immediately; no wb or exc is emitted.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - Captures when `ex_valid_i & (is_load | is_store) & !flush_i`.
  - Illegal funct3 (load: 011/110/111; store: ≥011): no request; next cycle `exc_valid_o=1`, cause 2; stay IDLE.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0): no request; next cycle exc pulse, cause 4 (load) or 6 (store), `tval=addr`; stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - `d_req_o.valid=1`, fields registered; all fields held stable until `ready`.
  - On `ready`: load → WAIT; store → IDLE (store complete, no wb).
  - `flush_i` with `ready=0`: drop valid next cycle, go IDLE.
  - `flush_i` with `ready=1`: transfer counts; store completes normally; load → DRAIN.
- WAIT:
  - `rvalid` is sampled only here, never in the acceptance cycle.
  - On `rvalid`: next cycle `wb_valid_o=1` with `rd` and extended data; go IDLE.
  - `flush_i` → DRAIN.
  - Timeout (if RESP_TIMEOUT>0): after RESP_TIMEOUT cycles without `rvalid`, exc cause 5 and go IDLE.
- DRAIN: wait for `rvalid`, discard the data, go IDLE; no wb, no exc.
- Stall: `lsu_stall_o = (state != IDLE)`, combinational from the state register.
- Byte enables:
  - byte: `be = 4'b0001 << addr[1:0]`
  - half: `be = 4'b0011 << addr[1:0]`
  - word: `be = 4'b1111`
- Store data: byte replicated ×4, half replicated ×2.
- `d_req_o.addr`: the full address, not word-aligned.
- Load extract: select byte/half by `addr[1:0]`; LB/LH sign-extend, LBU/LHU zero-extend.
- Latency: a load accepted in its first REQ cycle with `rvalid` one cycle later gives `wb_valid_o` 3 cycles after capture and stall high 2 cycles.
- Throughput: a new op can be captured in the cycle after returning to IDLE.

Decomposition:
- Add to `mem_interface_pkg`:
  - `lsu_state_e`
  - funct3 constants (LB…LHU, SB/SH/SW)
  - exception cause constants
  - a `be_for()` function
- Sub-module `lsu_load_align`: combinational rdata + funct3 + addr[1:0] → 32-bit extended result.

Test Plan:
1. LW 0x100, ready=1, rdata 0xDEADBEEF one cycle after acceptance -> `wb_valid_o` pulse at capture+3, `wb_data_o=0xDEADBEEF`, `wb_rd_o=ex_rd_i`, stall high 2 cycles.
2. LB 0x103 with rdata 0x80FFFFFF -> 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU 0x102 -> 0x000080FF.
3. SH 0x102, wdata 0x1234ABCD, ready low 3 cycles -> valid/addr/wdata=0xABCDABCD/be=1100/we=1 held stable, stall high; after ready -> IDLE, no wb.
4. LW 0x101 -> `d_req_o.valid` never rises, one-cycle exc cause 4, tval 0x101; SB with funct3 011 -> exc cause 2.
5. Load in WAIT, `flush_i` pulsed, rvalid 2 cycles later -> no `wb_valid_o`, stall drops the cycle after rvalid; next LW completes normally.
6. `rst_ni` low mid-WAIT -> all outputs 0 asynchronously; after release a new LW completes normally.
